// File: rtl/rca_lsu_result_router_if.sv
// Bundle of the LSQ issue, LSU writeback and grid result signals around the result router.
// The router takes the slave view; the LSQ/LSU/grid side takes the master view.
interface rca_lsu_result_router_if #(
  parameter int GRID_NUM_ROWS = 4,
  parameter int XLEN          = 32,
  parameter int TAG_DEPTH     = 4
);
  localparam int ROW_W = (GRID_NUM_ROWS > 1) ? $clog2(GRID_NUM_ROWS) : 1;
  localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

  logic                          issue_valid;
  logic                          issue_load;
  logic [ROW_W-1:0]              issue_row;
  logic                          issue_ready;
  logic                          wb_valid;
  logic [XLEN-1:0]               wb_data;
  logic                          wb_ack;
  logic [GRID_NUM_ROWS-1:0]      row_valid;
  logic [GRID_NUM_ROWS*XLEN-1:0] row_data;
  logic [GRID_NUM_ROWS-1:0]      row_ack;
  logic                          flush;
  logic [CNT_W-1:0]              outstanding;
  logic                          idle;
  logic                          protocol_err;

  modport master (
    output issue_valid, issue_load, issue_row, wb_valid, wb_data, row_ack, flush,
    input  issue_ready, wb_ack, row_valid, row_data, outstanding, idle, protocol_err
  );

  modport slave (
    input  issue_valid, issue_load, issue_row, wb_valid, wb_data, row_ack, flush,
    output issue_ready, wb_ack, row_valid, row_data, outstanding, idle, protocol_err
  );
endinterface

// File: rtl/rca_lsu_result_router.sv
// Tracks the issuing grid row of each outstanding load and steers in-order LSU
// writebacks into per-row result registers held until the row acknowledges.
module rca_lsu_result_router #(
  parameter int GRID_NUM_ROWS = 4,
  parameter int XLEN          = 32,
  parameter int TAG_DEPTH     = 4
) (
  input logic                    clk,
  input logic                    rst,
  rca_lsu_result_router_if.slave bus
);
  localparam int ROW_W = (GRID_NUM_ROWS > 1) ? $clog2(GRID_NUM_ROWS) : 1;
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ROW_W-1:0]              tag_q [TAG_DEPTH];
  logic [ROW_W-1:0]              tag_d [TAG_DEPTH];
  logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [GRID_NUM_ROWS-1:0]      row_valid_q, row_valid_d;
  logic [GRID_NUM_ROWS*XLEN-1:0] row_data_q, row_data_d;
  logic                          perr_q, perr_d;

  logic [ROW_W-1:0] head_row;
  logic             head_busy;
  logic             full, empty;
  logic             issue_ready, wb_ack;
  logic             push, pop;

  always_comb begin
    head_row  = tag_q[rd_ptr_q];
    head_busy = 1'b0;
    for (int r = 0; r < GRID_NUM_ROWS; r++) begin
      if (ROW_W'(r) == head_row) head_busy = row_valid_q[r];
    end
    full  = (cnt_q == CNT_W'(TAG_DEPTH));
    empty = (cnt_q == '0);
    // Ready is taken from the registered count, so a pop never frees a slot in the same cycle.
    issue_ready = ~rst & ~full;
    wb_ack      = ~rst & ~empty & ~head_busy & ~bus.flush;
    push        = bus.issue_valid & bus.issue_load & issue_ready & ~bus.flush;
    pop         = bus.wb_valid & wb_ack;
  end

  always_comb begin
    tag_d       = tag_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    row_valid_d = row_valid_q & ~bus.row_ack;
    row_data_d  = row_data_q;
    perr_d      = perr_q | (bus.wb_valid & empty);

    if (push) begin
      tag_d[wr_ptr_q] = bus.issue_row;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    for (int r = 0; r < GRID_NUM_ROWS; r++) begin
      if (pop && (ROW_W'(r) == head_row)) begin
        row_valid_d[r]                = 1'b1;
        row_data_d[r*XLEN +: XLEN]    = bus.wb_data;
      end
    end

    // Flush keeps row_data and the sticky error for post-mortem visibility.
    if (bus.flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      cnt_d       = '0;
      row_valid_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      row_valid_q <= '0;
      row_data_q  <= '0;
      perr_q      <= 1'b0;
    end else begin
      tag_q       <= tag_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      row_valid_q <= row_valid_d;
      row_data_q  <= row_data_d;
      perr_q      <= perr_d;
    end
  end

  assign bus.issue_ready  = issue_ready;
  assign bus.wb_ack       = wb_ack;
  assign bus.row_valid    = row_valid_q;
  assign bus.row_data     = row_data_q;
  assign bus.outstanding  = cnt_q;
  assign bus.idle         = empty & (row_valid_q == '0);
  assign bus.protocol_err = perr_q;
endmodule

// File: tb/tb_rca_lsu_result_router.sv
// Directed bench for rca_lsu_result_router: hand-computed expectations for
// issue/writeback routing, back-pressure, protocol error and flush.
module tb_rca_lsu_result_router;
  localparam int GR = 4;
  localparam int XL = 32;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  rca_lsu_result_router_if #(.GRID_NUM_ROWS(GR), .XLEN(XL), .TAG_DEPTH(TD)) bus ();

  rca_lsu_result_router #(.GRID_NUM_ROWS(GR), .XLEN(XL), .TAG_DEPTH(TD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; checks happen 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic [1:0] row);
    bus.issue_valid = 1'b1;
    bus.issue_load  = 1'b1;
    bus.issue_row   = row;
    cyc();
    bus.issue_valid = 1'b0;
  endtask

  task automatic wb(input logic [31:0] data, input string tag);
    bus.wb_valid = 1'b1;
    bus.wb_data  = data;
    settle();
    chk(tag, 64'(bus.wb_ack), 64'd1);
    cyc();
    bus.wb_valid = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    bus.issue_valid = 1'b0;
    bus.issue_load  = 1'b0;
    bus.issue_row   = '0;
    bus.wb_valid    = 1'b0;
    bus.wb_data     = '0;
    bus.row_ack     = '0;
    bus.flush       = 1'b0;
    cyc(); cyc();
    settle();
    chk("rst_issue_ready", 64'(bus.issue_ready), 64'd0);
    chk("rst_wb_ack",      64'(bus.wb_ack),      64'd0);
    rst = 1'b0;
    settle();
    chk("post_rst_ready",  64'(bus.issue_ready), 64'd1);
    chk("post_rst_idle",   64'(bus.idle),        64'd1);
    chk("post_rst_out",    64'(bus.outstanding), 64'd0);
    chk("post_rst_perr",   64'(bus.protocol_err),64'd0);

    // 1: single load to row 2
    issue(2'd2);
    chk("t1_out1", 64'(bus.outstanding), 64'd1);
    cyc(); cyc();
    wb(32'hDEADBEEF, "t1_wb_ack");
    settle();
    chk("t1_row_valid", 64'(bus.row_valid), 64'b0100);
    chk("t1_row_data2", 64'(bus.row_data[2*XL +: XL]), 64'hDEADBEEF);
    chk("t1_out0", 64'(bus.outstanding), 64'd0);
    chk("t1_not_idle", 64'(bus.idle), 64'd0);
    bus.row_ack = 4'b0100;
    cyc();
    bus.row_ack = '0;
    settle();
    chk("t1_idle", 64'(bus.idle), 64'd1);
    chk("t1_data_kept", 64'(bus.row_data[2*XL +: XL]), 64'hDEADBEEF);

    // 2: rows 0,3,1 in order
    issue(2'd0); issue(2'd3); issue(2'd1);
    chk("t2_out3", 64'(bus.outstanding), 64'd3);
    wb(32'hAAAA0001, "t2_ack_a");
    chk("t2_out2", 64'(bus.outstanding), 64'd2);
    wb(32'hBBBB0002, "t2_ack_b");
    chk("t2_out1", 64'(bus.outstanding), 64'd1);
    wb(32'hCCCC0003, "t2_ack_c");
    chk("t2_out0", 64'(bus.outstanding), 64'd0);
    chk("t2_row_valid", 64'(bus.row_valid), 64'b1011);
    chk("t2_row0", 64'(bus.row_data[0*XL +: XL]), 64'hAAAA0001);
    chk("t2_row3", 64'(bus.row_data[3*XL +: XL]), 64'hBBBB0002);
    chk("t2_row1", 64'(bus.row_data[1*XL +: XL]), 64'hCCCC0003);
    bus.row_ack = 4'b1011;
    cyc();
    bus.row_ack = '0;
    settle();
    chk("t2_multi_ack", 64'(bus.row_valid), 64'b0000);

    // 3: fill the tag FIFO
    issue(2'd0); issue(2'd1); issue(2'd2); issue(2'd3);
    chk("t3_full_ready", 64'(bus.issue_ready), 64'd0);
    chk("t3_out4", 64'(bus.outstanding), 64'd4);
    issue(2'd0);
    chk("t3_no_push", 64'(bus.outstanding), 64'd4);
    bus.issue_valid = 1'b1;
    bus.issue_load  = 1'b1;
    bus.issue_row   = 2'd0;
    bus.wb_valid    = 1'b1;
    bus.wb_data     = 32'h00000A00;
    settle();
    chk("t3_no_bypass", 64'(bus.issue_ready), 64'd0);
    chk("t3_wb_ack", 64'(bus.wb_ack), 64'd1);
    cyc();
    bus.issue_valid = 1'b0;
    bus.wb_valid    = 1'b0;
    settle();
    chk("t3_out3", 64'(bus.outstanding), 64'd3);
    chk("t3_ready_again", 64'(bus.issue_ready), 64'd1);
    wb(32'h00000A01, "t3_ack_r1");
    wb(32'h00000A02, "t3_ack_r2");
    wb(32'h00000A03, "t3_ack_r3");
    chk("t3_rv_all", 64'(bus.row_valid), 64'b1111);
    chk("t3_row0", 64'(bus.row_data[0*XL +: XL]), 64'h00000A00);
    chk("t3_row3", 64'(bus.row_data[3*XL +: XL]), 64'h00000A03);
    bus.row_ack = 4'b1111;
    cyc();
    bus.row_ack = '0;
    settle();
    chk("t3_idle", 64'(bus.idle), 64'd1);

    // 4: head row occupied stalls the writeback
    issue(2'd1); issue(2'd1);
    wb(32'h11110001, "t4_ack_first");
    bus.wb_valid = 1'b1;
    bus.wb_data  = 32'h22220002;
    settle();
    chk("t4_stall", 64'(bus.wb_ack), 64'd0);
    cyc();
    chk("t4_hold_data", 64'(bus.row_data[1*XL +: XL]), 64'h11110001);
    chk("t4_hold_out", 64'(bus.outstanding), 64'd1);
    bus.row_ack = 4'b0010;
    settle();
    chk("t4_ack_indep", 64'(bus.wb_ack), 64'd0);
    cyc();
    bus.row_ack = '0;
    settle();
    chk("t4_resume", 64'(bus.wb_ack), 64'd1);
    cyc();
    bus.wb_valid = 1'b0;
    settle();
    chk("t4_row1", 64'(bus.row_data[1*XL +: XL]), 64'h22220002);
    chk("t4_rv", 64'(bus.row_valid), 64'b0010);
    bus.row_ack = 4'b0011;
    cyc();
    bus.row_ack = '0;
    settle();
    chk("t4_ack_invalid_ignored", 64'(bus.row_valid), 64'b0000);

    // 5: writeback with nothing outstanding
    bus.wb_valid = 1'b1;
    bus.wb_data  = 32'hBAD0BAD0;
    settle();
    chk("t5_wb_ack", 64'(bus.wb_ack), 64'd0);
    cyc();
    bus.wb_valid = 1'b0;
    settle();
    chk("t5_perr", 64'(bus.protocol_err), 64'd1);
    cyc(); cyc();
    chk("t5_perr_sticky", 64'(bus.protocol_err), 64'd1);
    chk("t5_rv", 64'(bus.row_valid), 64'b0000);

    // 6: flush with loads outstanding and a held result
    issue(2'd0); issue(2'd1); issue(2'd2);
    wb(32'h33334444, "t6_ack_row0");
    issue(2'd3);
    chk("t6_out3", 64'(bus.outstanding), 64'd3);
    chk("t6_rv", 64'(bus.row_valid), 64'b0001);
    bus.flush       = 1'b1;
    bus.issue_valid = 1'b1;
    bus.issue_load  = 1'b1;
    bus.issue_row   = 2'd3;
    settle();
    chk("t6_flush_wb_ack", 64'(bus.wb_ack), 64'd0);
    cyc();
    bus.flush       = 1'b0;
    bus.issue_valid = 1'b0;
    settle();
    chk("t6_out0", 64'(bus.outstanding), 64'd0);
    chk("t6_rv0", 64'(bus.row_valid), 64'b0000);
    chk("t6_ready", 64'(bus.issue_ready), 64'd1);
    chk("t6_perr_kept", 64'(bus.protocol_err), 64'd1);
    chk("t6_data_kept", 64'(bus.row_data[0*XL +: XL]), 64'h33334444);
    bus.issue_valid = 1'b1;
    bus.issue_load  = 1'b0;
    bus.issue_row   = 2'd1;
    cyc();
    bus.issue_valid = 1'b0;
    settle();
    chk("t6_store_out", 64'(bus.outstanding), 64'd0);
    chk("t6_store_idle", 64'(bus.idle), 64'd1);

    rst = 1'b1;
    cyc();
    rst = 1'b0;
    settle();
    chk("final_perr_clr", 64'(bus.protocol_err), 64'd0);
    chk("final_data_clr", 64'(bus.row_data[0*XL +: XL]), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
